seg7_scan_driver: RTL

Time-multiplexed driver for a bank of common-anode/cathode 7-segment displays. It generalises the single-digit registered hex decoder to `DIGITS` digits sharing one segment bus. It also adds:
- a refresh divider,
- frame-coherent input sampling,
- leading-zero blanking,
- per-digit decimal points,
- a global display enable.

It sits between the UART datapath registers and the board's segment and anode pins.

---
 rtl/seg7_scan_driver.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
//   Time-multiplexed driver for DIGITS seven-segment digits on one shared
//   segment bus. A refresh divider steps through the digits, the input
//   nibbles and decimal points are captured once per frame, leading zeros
//   can be blanked, and a global enable turns every digit off.
//
// Parameters
//   DIGITS     number of digits (>=1)
//   CLK_DIV    clock cycles each digit stays lit (>=2)
//   ACTIVE_LOW 1: seg/dp/an are active-low, 0: active-high
//   BLANK_LZ   1: blank leading zero digits, 0: show every digit
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in         hex nibbles, digit k = in[4k+3:4k], digit 0 rightmost
//   dp_in      decimal point request per digit
//   en         display enable, 0 turns all anodes/segments/dp off
//   seg        registered segments {g,f,e,d,c,b,a}
//   dp         registered decimal point
//   an         registered one-hot anode select
//   frame_tick one-cycle pulse on the cycle after the shadow registers load
module seg7_scan_driver #(
    parameter int unsigned DIGITS     = 4,
    parameter int unsigned CLK_DIV    = 50000,
    parameter int unsigned ACTIVE_LOW = 1,
    parameter int unsigned BLANK_LZ   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   in,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  en,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [DIGITS-1:0]     an,
    output logic                  frame_tick
);

    localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);
    localparam logic          POL      = (ACTIVE_LOW != 0);
    localparam logic          LZ_EN    = (BLANK_LZ != 0);

    logic [CW-1:0]         cnt;
    logic [IW-1:0]         idx;
    logic [4*DIGITS-1:0]   in_s;
    logic [DIGITS-1:0]     dp_s;
    logic                  digit_end;
    logic                  frame_end;

    logic [DIGITS-1:0]     lz;
    logic                  zero_run;
    int unsigned           kk;
    logic [3:0]            nib;
    logic                  dp_sel;
    logic                  blank_sel;
    logic [6:0]            seg_c;
    logic                  dp_c;
    logic [DIGITS-1:0]     an_c;

    function automatic logic [6:0] hex7(input logic [3:0] h);
        logic [6:0] s;
        case (h)
            4'h0:    s = 7'b0111111;
            4'h1:    s = 7'b0000110;
            4'h2:    s = 7'b1011011;
            4'h3:    s = 7'b1001111;
            4'h4:    s = 7'b1100110;
            4'h5:    s = 7'b1101101;
            4'h6:    s = 7'b1111101;
            4'h7:    s = 7'b0000111;
            4'h8:    s = 7'b1111111;
            4'h9:    s = 7'b1101111;
            4'hA:    s = 7'b1110111;
            4'hB:    s = 7'b1111100;
            4'hC:    s = 7'b0111001;
            4'hD:    s = 7'b1011110;
            4'hE:    s = 7'b1111001;
            default: s = 7'b1110001;
        endcase
        return s;
    endfunction

    assign digit_end = (cnt == CNT_LAST);
    assign frame_end = digit_end && (idx == IDX_LAST);

    // Divider, digit index and frame snapshot
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            idx        <= '0;
            in_s       <= '0;
            dp_s       <= '0;
            frame_tick <= 1'b0;
        end else begin
            cnt <= digit_end ? '0 : cnt + CW'(1);
            if (digit_end)
                idx <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
            // Snapshot coincides with the wrap back to digit 0
            if (frame_end) begin
                in_s <= in;
                dp_s <= dp_in;
            end
            frame_tick <= frame_end;
        end
    end

    // lz[k]: every shadow nibble from k up to the top is zero (digit 0 exempt)
    always_comb begin
        lz       = '0;
        zero_run = 1'b1;
        kk       = 0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            kk       = DIGITS - 1 - i;
            zero_run = zero_run & (in_s[4*kk +: 4] == 4'h0);
            lz[kk]   = LZ_EN && zero_run && (kk != 0);
        end
    end

    // Select the current digit and build active-high output values
    always_comb begin
        nib       = '0;
        dp_sel    = 1'b0;
        blank_sel = 1'b0;
        an_c      = '0;
        for (int unsigned k = 0; k < DIGITS; k++) begin
            if (idx == IW'(k)) begin
                nib       = in_s[4*k +: 4];
                dp_sel    = dp_s[k];
                blank_sel = lz[k];
                an_c[k]   = en;
            end
        end
        seg_c = (en && !blank_sel) ? hex7(nib) : '0;
        dp_c  = en && dp_sel;
    end

    // Output registers; polarity applied here so inactive is all-ones when active-low
    always_ff @(posedge clk) begin
        if (rst) begin
            seg <= {7{POL}};
            dp  <= POL;
            an  <= {DIGITS{POL}};
        end else begin
            seg <= seg_c ^ {7{POL}};
            dp  <= dp_c ^ POL;
            an  <= an_c ^ {DIGITS{POL}};
        end
    end

endmodule
